// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// Memory-stage load/store unit of the 5-stage RV32I pipeline. It accepts one
// op per in_valid handshake while idle. Non-memory ops are forwarded to
// writeback on the next cycle. Misaligned or UNDEF-size memory ops are dropped
// and flagged. Aligned memory ops drive a word-addressed data memory through a
// req/ready handshake. Load data is lane-extracted and sign/zero-extended.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   EX/MEM handshake (in_ready high only when idle)
//   in_is_load/store    op class (both set is treated as a load)
//   in_size             data size: 0 UNDEF, 1 BYTE_S, 2 BYTE_U, 3 HALF_S,
//                       4 HALF_U, 5 WORD (6/7 behave as UNDEF)
//   in_addr             effective address, or the result of a non-memory op
//   in_wdata, in_rd     store data, destination register
//   mem_*               data-memory request (registered, held until mem_ready)
//   mem_rdata/mem_ready read data and accept/complete strobe
//   wb_valid/rd/data    registered writeback result (wb_valid is a 1-cycle pulse)
//   misaligned          1-cycle pulse when a memory op is dropped
module mem_stage_lsu #(
    parameter int ADDR_WIDTH = 9,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_size,
    input  logic [XLEN-1:0]       in_addr,
    input  logic [XLEN-1:0]       in_wdata,
    input  logic [4:0]            in_rd,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  mem_ready,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  misaligned
);

    localparam logic [2:0] SZ_BYTE_S = 3'd1;
    localparam logic [2:0] SZ_BYTE_U = 3'd2;
    localparam logic [2:0] SZ_HALF_S = 3'd3;
    localparam logic [2:0] SZ_HALF_U = 3'd4;
    localparam logic [2:0] SZ_WORD   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic                  mis_q, mis_d;
    // Op context kept for the load response.
    logic [2:0]            size_q, size_d;
    logic [1:0]            off_q, off_d;
    logic                  is_ld_q, is_ld_d;
    logic [4:0]            rd_q, rd_d;

    logic                  is_mem;
    logic                  bad_align;
    logic [3:0]            st_be;
    logic [XLEN-1:0]       st_wdata;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [XLEN-1:0]       ld_data;

    assign is_mem = in_is_load | in_is_store;

    // Alignment / size legality of the incoming op; bytes are always aligned.
    always_comb begin
        bad_align = 1'b1;
        case (in_size)
            SZ_BYTE_S, SZ_BYTE_U: bad_align = 1'b0;
            SZ_HALF_S, SZ_HALF_U: bad_align = in_addr[0];
            SZ_WORD:              bad_align = |in_addr[1:0];
            default:              bad_align = 1'b1;
        endcase
    end

    // Store lane steering: replicate the data so every enabled lane sees it.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = in_wdata;
        case (in_size)
            SZ_BYTE_S, SZ_BYTE_U: begin
                st_be    = 4'b0001 << in_addr[1:0];
                st_wdata = {4{in_wdata[7:0]}};
            end
            SZ_HALF_S, SZ_HALF_U: begin
                st_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{in_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction from the latched offset/size.
    always_comb begin
        ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_BYTE_S: ld_data = {{24{ld_byte[7]}}, ld_byte};
            SZ_BYTE_U: ld_data = {24'd0, ld_byte};
            SZ_HALF_S: ld_data = {{16{ld_half[15]}}, ld_half};
            SZ_HALF_U: ld_data = {16'd0, ld_half};
            default:   ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        mis_d       = 1'b0;
        size_d      = size_q;
        off_d       = off_q;
        is_ld_d     = is_ld_q;
        rd_d        = rd_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = in_rd;
                        wb_data_d  = in_addr;
                    end else if (bad_align) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ~in_is_load;
                        mem_addr_d  = in_addr[ADDR_WIDTH+1:2];
                        mem_be_d    = in_is_load ? 4'b1111 : st_be;
                        mem_wdata_d = st_wdata;
                        size_d      = in_size;
                        off_d       = in_addr[1:0];
                        is_ld_d     = in_is_load;
                        rd_d        = in_rd;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (is_ld_q) begin
                        // Writeback is registered here so it shows in RESP.
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = ld_data;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            mis_q       <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            is_ld_q     <= 1'b0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            mis_q       <= mis_d;
            size_q      <= size_d;
            off_q       <= off_d;
            is_ld_q     <= is_ld_d;
            rd_q        <= rd_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    localparam logic [2:0] UNDEF = 3'd0, BYTE_S = 3'd1, BYTE_U = 3'd2,
                           HALF_S = 3'd3, HALF_U = 3'd4, WORD = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic        in_is_load = 1'b0, in_is_store = 1'b0;
    logic [2:0]  in_size = 3'd0;
    logic [31:0] in_addr = 32'd0, in_wdata = 32'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic        wb_valid, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_WIDTH(9), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misaligned(misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: 0 = non-memory, 1 = dropped, 2 = memory access.
    function automatic int kind(input logic ld, input logic st, input logic [2:0] sz,
                                input logic [31:0] a);
        if (!ld && !st) return 0;
        if (sz == BYTE_S || sz == BYTE_U) return 2;
        if (sz == HALF_S || sz == HALF_U) return (a % 2 == 0) ? 2 : 1;
        if (sz == WORD) return (a % 4 == 0) ? 2 : 1;
        return 1;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] sz, input logic [31:0] a);
        if (sz == BYTE_S || sz == BYTE_U) return 4'(1 << (a % 4));
        if (sz == HALF_S || sz == HALF_U) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] sz, input logic [31:0] d);
        if (sz == BYTE_S || sz == BYTE_U) return (d % 256) * 32'h0101_0101;
        if (sz == HALF_S || sz == HALF_U) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [2:0] sz, input logic [31:0] a,
                                           input logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * (a % 4))) % 256;
        h = (r >> (16 * ((a % 4) / 2))) % 65536;
        case (sz)
            BYTE_S:  return (b >= 128) ? b - 32'd256 : b;
            BYTE_U:  return b;
            HALF_S:  return (h >= 32768) ? h - 32'd65536 : h;
            HALF_U:  return h;
            default: return r;
        endcase
    endfunction

    // Issue one op at the current cycle (caller is #1 after an edge) and check
    // the whole transaction against the model; dly = ready-wait cycles.
    task automatic do_op(input string tag, input logic ld, input logic st,
                         input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input int dly, input logic [31:0] rdata);
        int k;
        k = kind(ld, st, sz, a);
        chk({tag, ".in_ready"}, in_ready, 1'b1);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st;
        in_size = sz; in_addr = a; in_wdata = wd; in_rd = rd;
        tick();
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_addr = $urandom; in_wdata = $urandom; in_size = 3'($urandom);
        if (k == 0) begin
            chk({tag, ".wb_valid"}, wb_valid, 1'b1);
            chk({tag, ".wb_data"}, wb_data, a);
            chk({tag, ".wb_rd"}, wb_rd, rd);
            chk({tag, ".mem_req"}, mem_req, 1'b0);
            tick();
            chk({tag, ".wb_drop"}, wb_valid, 1'b0);
        end else if (k == 1) begin
            chk({tag, ".misaligned"}, misaligned, 1'b1);
            chk({tag, ".mem_req"}, mem_req, 1'b0);
            chk({tag, ".wb_valid"}, wb_valid, 1'b0);
            tick();
            chk({tag, ".mis_drop"}, misaligned, 1'b0);
            chk({tag, ".mem_req2"}, mem_req, 1'b0);
        end else begin
            for (int d = 0; d <= dly; d++) begin
                chk({tag, ".mem_req"}, mem_req, 1'b1);
                chk({tag, ".mem_we"}, mem_we, !ld);
                chk({tag, ".mem_addr"}, mem_addr, (a / 4) % 512);
                chk({tag, ".mem_be"}, mem_be, ld ? 4'hF : exp_be(sz, a));
                if (!ld) chk({tag, ".mem_wdata"}, mem_wdata, exp_wd(sz, wd));
                chk({tag, ".in_ready"}, in_ready, 1'b0);
                chk({tag, ".wb_idle"}, wb_valid, 1'b0);
                mem_ready = (d == dly);
                mem_rdata = (d == dly) ? rdata : $urandom;
                tick();
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            chk({tag, ".req_drop"}, mem_req, 1'b0);
            if (ld) begin
                chk({tag, ".wb_valid"}, wb_valid, 1'b1);
                chk({tag, ".wb_data"}, wb_data, exp_ld(sz, a, rdata));
                chk({tag, ".wb_rd"}, wb_rd, rd);
                chk({tag, ".resp_ready"}, in_ready, 1'b0);
                tick();
                chk({tag, ".wb_drop"}, wb_valid, 1'b0);
                chk({tag, ".idle"}, in_ready, 1'b1);
            end else begin
                chk({tag, ".wb_none"}, wb_valid, 1'b0);
                chk({tag, ".idle"}, in_ready, 1'b1);
            end
        end
    endtask

    initial begin
        // Reset held 2 cycles with a valid op present.
        in_valid = 1'b1; in_addr = 32'h1234_5678; in_rd = 5'd7;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst.mem_req", mem_req, 1'b0);
            chk("rst.mem_we", mem_we, 1'b0);
            chk("rst.mem_addr", mem_addr, 9'd0);
            chk("rst.mem_be", mem_be, 4'd0);
            chk("rst.mem_wdata", mem_wdata, 32'd0);
            chk("rst.wb_valid", wb_valid, 1'b0);
            chk("rst.wb_rd", wb_rd, 5'd0);
            chk("rst.wb_data", wb_data, 32'd0);
            chk("rst.misaligned", misaligned, 1'b0);
            chk("rst.in_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        do_op("sw", 1'b0, 1'b1, WORD, 32'h0000_0104, 32'hDEAD_BEEF, 5'd3, 3, 32'd0);
        do_op("sb", 1'b0, 1'b1, BYTE_U, 32'h0000_0013, 32'h0000_00A5, 5'd3, 0, 32'd0);
        do_op("lb_s", 1'b1, 1'b0, BYTE_S, 32'h0000_0002, 32'd0, 5'd9, 0, 32'h0080_0000);
        do_op("lbu", 1'b1, 1'b0, BYTE_U, 32'h0000_0002, 32'd0, 5'd9, 0, 32'h0080_0000);
        do_op("lh_s", 1'b1, 1'b0, HALF_S, 32'h0000_0002, 32'd0, 5'd10, 0, 32'h8001_1234);
        do_op("lw_rd0", 1'b1, 1'b0, WORD, 32'h0000_0008, 32'd0, 5'd0, 1, 32'hCAFE_F00D);
        do_op("ld_st", 1'b1, 1'b1, HALF_U, 32'h0000_0006, 32'd0, 5'd4, 0, 32'hBEEF_0001);
        do_op("lw_mis", 1'b1, 1'b0, WORD, 32'h0000_0006, 32'd0, 5'd1, 0, 32'd0);
        do_op("lhu_mis", 1'b1, 1'b0, HALF_U, 32'h0000_0101, 32'd0, 5'd1, 0, 32'd0);
        do_op("undef", 1'b0, 1'b1, UNDEF, 32'h0000_0000, 32'd0, 5'd1, 0, 32'd0);

        // Back-to-back non-memory ops.
        in_valid = 1'b1; in_addr = 32'h11; in_rd = 5'd5;
        tick();
        chk("b2b.wb_valid0", wb_valid, 1'b1);
        chk("b2b.wb_data0", wb_data, 32'h11);
        chk("b2b.wb_rd0", wb_rd, 5'd5);
        chk("b2b.ready0", in_ready, 1'b1);
        in_addr = 32'h22; in_rd = 5'd6;
        tick();
        in_valid = 1'b0;
        chk("b2b.wb_valid1", wb_valid, 1'b1);
        chk("b2b.wb_data1", wb_data, 32'h22);
        chk("b2b.wb_rd1", wb_rd, 5'd6);
        chk("b2b.ready1", in_ready, 1'b1);
        tick();
        chk("b2b.wb_drop", wb_valid, 1'b0);
        chk("b2b.hold_data", wb_data, 32'h22);

        // Reset during ACCESS abandons the request.
        in_valid = 1'b1; in_is_load = 1'b1; in_size = WORD; in_addr = 32'h40; in_rd = 5'd8;
        tick();
        in_valid = 1'b0; in_is_load = 1'b0;
        chk("rstacc.mem_req", mem_req, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("rstacc.req_drop", mem_req, 1'b0);
        chk("rstacc.in_ready", in_ready, 1'b1);
        chk("rstacc.wb_valid", wb_valid, 1'b0);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rstacc.wb_after", wb_valid, 1'b0);
        chk("rstacc.req_after", mem_req, 1'b0);

        // Randomized ops against the model.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_op("rnd", 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), a,
                  $urandom, 5'($urandom), $urandom_range(0, 3), $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit of the 5-stage RV32I pipeline. It sits between the EX/MEM pipeline register and writeback.
- Accepts one op per handshake and drives a word-addressed data memory with byte enables and a req/ready handshake.
- Extracts and sign/zero-extends load data, then presents a registered writeback result.
- Stalls upstream while a memory access is outstanding.

Parameters:
ADDR_WIDTH, 9, data-memory word-address width; mem_addr = addr[ADDR_WIDTH+1:2]
XLEN, 32, datapath width (fixed at 32; no other value supported)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  EX/MEM op valid
in_ready  out  1  unit can accept an op (state==IDLE)
in_is_load  in  1  op is a load
in_is_store  in  1  op is a store
in_size  in  3  data_size_e (UNDEF/BYTE_S/BYTE_U/HALF_S/HALF_U/WORD)
in_addr  in  32  ALU result: effective address, or result for non-memory ops
in_wdata  in  32  rs2 store data
in_rd  in  5  destination register
mem_req  out  1  memory request, held until accepted
mem_we  out  1  1=write
mem_addr  out  ADDR_WIDTH  word address
mem_be  out  4  byte enables
mem_wdata  out  32  lane-aligned store data
mem_rdata  in  32  read data, valid in the cycle mem_ready=1
mem_ready  in  1  memory accepts/completes the request this cycle
wb_valid  out  1  writeback valid (1-cycle pulse)
wb_rd  out  5  writeback register
wb_data  out  32  writeback value
misaligned  out  1  1-cycle pulse: misaligned or UNDEF-size memory op dropped

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. All outputs deassert: mem_req, mem_we, wb_valid, misaligned = 0; mem_addr, mem_be, mem_wdata, wb_rd, wb_data = 0.
  - Reset mid-access abandons the request immediately; no writeback occurs.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: in_ready=1. A handshake occurs when in_valid=1.
  - Non-memory op (neither is_load nor is_store): next cycle wb_valid=1, wb_data=in_addr, wb_rd=in_rd; stay in IDLE. Throughput is 1/cycle.
  - in_is_load and in_is_store both 1: treat as a load.
  - Memory op, misaligned: HALF_* with addr[0]=1, WORD with addr[1:0]!=0, or size UNDEF. Next cycle misaligned=1, no mem_req, no wb_valid; stay in IDLE.
  - Memory op, aligned: latch op and go to ACCESS. mem_req=1 from the next cycle (registered).
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are stable until mem_ready=1.
  - On mem_ready=1 at a posedge:
    - store: mem_req drops next cycle; go to IDLE.
    - load: capture mem_rdata; go to RESP.
- RESP: wb_valid=1 for exactly one cycle with the extended load data; go to IDLE. in_ready=0 in RESP.
- Latency:
  - store: request at cycle N+1 after handshake; IDLE the cycle after ready.
  - load with ready in the first ACCESS cycle: wb_valid at N+2.
- Store lanes (o = addr[1:0]):
  - BYTE: be = 4'b0001<<o; wdata = {4{wdata[7:0]}}.
  - HALF: be = 0011 (o=0) or 1100 (o=2); wdata = {2{wdata[15:0]}}.
  - WORD: be = 1111; wdata unchanged.
  - Loads drive be=1111 and we=0.
- Load extraction: byte = rdata[8*o +: 8]; half = rdata[16*o[1] +: 16].
  - *_S sign-extends; *_U zero-extends; WORD passes through.
- rd=0: loads and non-memory ops still pulse wb_valid with wb_rd=0; the register file ignores x0.
- Outside pulses, wb_valid and misaligned are 0. wb_data and wb_rd hold their last values.

Test Plan:
- Reset: hold rst_n=0 2 cycles while in_valid=1 → all outputs 0, in_ready=1. Assert rst_n=0 during ACCESS → next cycle mem_req=0, state IDLE, no wb_valid.
- SW addr=0x0000_0104, wdata=0xDEADBEEF, mem_ready delayed 3 cycles → mem_req held 3 cycles with addr=0x041, be=1111, we=1; in_ready=0 throughout; no wb_valid.
- SB addr=0x0000_0013, wdata=0x0000_00A5 → be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x004.
- LB_S addr=0x0000_0002, rdata=0x0080_0000, immediate ready → wb_valid at N+2 with wb_data=0xFFFF_FF80; LBU same → 0x0000_0080; LH_S at o=2 with rdata=0x8001_xxxx → 0xFFFF_8001.
- LW addr=0x0000_0006 → misaligned pulse next cycle, mem_req never asserted, no wb_valid. HALF_U addr=0x...1 → same. Size UNDEF → same.
- Back-to-back non-memory ops rd=5/6, values 0x11/0x22 on consecutive cycles → wb_valid two consecutive cycles carrying each value; in_ready stays 1.
